button_debouncer: RTL and testbench
===================================

# button_debouncer

Consumes the 20 Hz `clk_debounce` enable pulse from the clock-divider block and turns the raw, bouncing Nexys3 push-button inputs into clean levels, single-cycle press/release strobes and an optional auto-repeat strobe. Sits between the board pins and the control logic (camera/disparity mode selection, display paging). It runs entirely in the 24 MHz camera clock domain, where `clk_debounce` is generated.

## Interface

- `NUM_BTNS`, 5: number of independent buttons.
- `STABLE_TICKS`, 2: consecutive disagreeing tick samples required to flip a debounced level (1..15).
- `REPEAT_DELAY`, 10: ticks a button must stay held before the first repeat strobe; 0 disables auto-repeat.
- `REPEAT_RATE`, 4: ticks between subsequent repeat strobes (1..255).

- `clk_cam`  in  1  24 MHz clock; the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `clk_debounce`  in  1  one-`clk_cam`-cycle enable pulse at 20 Hz, synchronous to `clk_cam`.
- `btn_raw`  in  NUM_BTNS  asynchronous raw button pins, active-high.
- `btn_level`  out  NUM_BTNS  debounced level.
- `btn_press`  out  NUM_BTNS  one-cycle strobe on a debounced 0→1 transition.
- `btn_release`  out  NUM_BTNS  one-cycle strobe on a debounced 1→0 transition.
- `btn_repeat`  out  NUM_BTNS  one-cycle auto-repeat strobe while held.

## Operation

- Reset (`reset_n` low, asynchronous): synchronizers, levels, counters and strobes clear to 0. Repeat FSMs go to IDLE. All outputs are 0 while reset is held.
- Each bit passes through a 2-flop synchronizer. Only the second flop (`sync`) is used downstream.
- Sampling happens only in cycles where `clk_debounce`=1. In all other cycles, state holds.
- Per-bit agree counter (4 bits), updated on each tick:
  - `sync` == `btn_level`: counter cleared to 0.
  - `sync` != `btn_level`: counter increments. When the incremented value reaches `STABLE_TICKS`, `btn_level` inverts and the counter clears.
- Strobes are registered and asserted in the cycle after the tick edge that flips the level:
  - 0→1 flip: `btn_press` = 1 for exactly one cycle.
  - 1→0 flip: `btn_release` = 1 for exactly one cycle.
- Per-bit repeat FSM with an 8-bit tick counter `rc`:
  - IDLE: on a press flip, go to HELD with `rc`=0.
  - HELD: each tick, `rc`++. When `rc` reaches `REPEAT_DELAY`, pulse `btn_repeat`, set `rc`=0 and go to REPEATING.
  - REPEATING: each tick, `rc`++. When `rc` reaches `REPEAT_RATE`, pulse `btn_repeat` and set `rc`=0.
  - Any state: a release flip returns the FSM to IDLE with `rc`=0.
  - `REPEAT_DELAY`=0: the FSM stays in IDLE and `btn_repeat` is constant 0.
- Buttons are fully independent. Any combination of bits may strobe in the same cycle.

## Timing

- Latency from a clean `btn_raw` edge to the `btn_level` change:
  - 2 cycles of synchronizer delay, then
  - `STABLE_TICKS` ticks, counting the first tick at least 2 cycles after the edge, then
  - 1 cycle to the register update.
  - At 20 Hz with `STABLE_TICKS`=2, this is 50–100 ms.
- `btn_press`/`btn_release` go high in the same cycle `btn_level` changes, for one cycle only.
- Bounce: any tick sampling the old level clears the agree counter, so a glitch shorter than one tick period never flips the level.
- Tick and release flip in the same cycle: the release wins. No `btn_repeat` fires in that cycle, even if `rc` would have reached its terminal count.
- The first repeat strobe comes `REPEAT_DELAY` ticks after the press flip. Later strobes come every `REPEAT_RATE` ticks.
- `clk_debounce` held high for several cycles is out of contract. Each high cycle counts as one tick.
- Reset asserted mid-press: all outputs drop to 0 immediately (asynchronously), with no `btn_release` strobe. After deassertion, a still-held button produces a fresh `btn_press` after the normal latency.

## Test plan

- Clean press: `NUM_BTNS`=5, `STABLE_TICKS`=2, ticks every 10 cycles; raise `btn_raw[0]` and hold. Expect `btn_level[0]`=1 and a one-cycle `btn_press[0]` on the second tick after sync; other bits stay 0.
- Bounce rejection: toggle `btn_raw[2]` every 3 cycles for 40 cycles, then hold at 1. Expect no strobe during the toggling, then exactly one `btn_press[2]` two ticks after it settles.
- Release: with `btn_level[1]`=1, drop `btn_raw[1]`. Expect one `btn_release[1]` two ticks later, and `btn_level[1]`=0.
- Auto-repeat: `REPEAT_DELAY`=3, `REPEAT_RATE`=2; hold `btn_raw[3]` for 12 ticks past the press. Expect `btn_repeat[3]` at ticks 3, 5, 7, 9 and 11 after the press flip, and none after release.
- Simultaneous events: press bits 0 and 4 in the same cycle. Expect `btn_press`=5'b10001 in a single cycle. Separately, align the release flip with a repeat terminal tick and expect no `btn_repeat`.
- Reset mid-operation: with bit 3 in REPEATING, pulse `reset_n` low for 1 cycle while still holding. Expect all outputs 0 immediately, no `btn_release`, then a new `btn_press[3]` after the normal latency.

Source files
------------

// File: rtl/button_debouncer.sv
// Push-button conditioner: 2-flop synchronizer, tick-sampled agree counter,
// registered press/release strobes and a per-button auto-repeat FSM.
//
// state        | meaning
// ST_IDLE      | debounced level low, or auto-repeat disabled
// ST_HELD      | pressed, counting REPEAT_DELAY ticks to the first repeat
// ST_REPEATING | first repeat issued, strobing every REPEAT_RATE ticks
module button_debouncer #(
   parameter int NUM_BTNS     = 5,
   parameter int STABLE_TICKS = 2,
   parameter int REPEAT_DELAY = 10,
   parameter int REPEAT_RATE  = 4
) (
   input  logic                clk_cam,
   input  logic                reset_n,
   input  logic                clk_debounce,
   input  logic [NUM_BTNS-1:0] btn_raw,
   output logic [NUM_BTNS-1:0] btn_level,
   output logic [NUM_BTNS-1:0] btn_press,
   output logic [NUM_BTNS-1:0] btn_release,
   output logic [NUM_BTNS-1:0] btn_repeat
);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_HELD      = 2'd1,
      ST_REPEATING = 2'd2
   } rpt_state_t;

   localparam logic [3:0] STABLE_C  = 4'(STABLE_TICKS);
   localparam logic [7:0] DELAY_C   = 8'(REPEAT_DELAY);
   localparam logic [7:0] RATE_C    = 8'(REPEAT_RATE);
   localparam bit         REPEAT_EN = (REPEAT_DELAY != 0);

   logic [NUM_BTNS-1:0] meta_q, sync_q;
   logic [NUM_BTNS-1:0] level_q, level_d;
   logic [NUM_BTNS-1:0] press_q, release_q;
   logic [NUM_BTNS-1:0] repeat_q, repeat_d;
   logic [NUM_BTNS-1:0] rise, fall;
   logic [3:0]          cnt_q   [NUM_BTNS];
   logic [3:0]          cnt_d   [NUM_BTNS];
   logic [7:0]          rc_q    [NUM_BTNS];
   logic [7:0]          rc_d    [NUM_BTNS];
   rpt_state_t          state_q [NUM_BTNS];
   rpt_state_t          state_d [NUM_BTNS];

   always_comb begin
      level_d = level_q;
      rise    = '0;
      fall    = '0;
      for (int i = 0; i < NUM_BTNS; i++) begin
         cnt_d[i] = cnt_q[i];
         if (clk_debounce) begin
            if (sync_q[i] == level_q[i]) begin
               cnt_d[i] = '0;
            end else if (cnt_q[i] + 4'd1 == STABLE_C) begin
               cnt_d[i]   = '0;
               level_d[i] = ~level_q[i];
               rise[i]    = ~level_q[i];
               fall[i]    = level_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 4'd1;
            end
         end
      end
   end

   // A release flip overrides any repeat terminal count reached on the same tick.
   always_comb begin
      repeat_d = '0;
      for (int i = 0; i < NUM_BTNS; i++) begin
         state_d[i] = state_q[i];
         rc_d[i]    = rc_q[i];
         if (!REPEAT_EN || fall[i]) begin
            state_d[i] = ST_IDLE;
            rc_d[i]    = '0;
         end else if (clk_debounce) begin
            case (state_q[i])
               ST_IDLE: begin
                  if (rise[i]) begin
                     state_d[i] = ST_HELD;
                     rc_d[i]    = '0;
                  end
               end
               ST_HELD: begin
                  if (rc_q[i] + 8'd1 == DELAY_C) begin
                     repeat_d[i] = 1'b1;
                     rc_d[i]     = '0;
                     state_d[i]  = ST_REPEATING;
                  end else begin
                     rc_d[i] = rc_q[i] + 8'd1;
                  end
               end
               ST_REPEATING: begin
                  if (rc_q[i] + 8'd1 == RATE_C) begin
                     repeat_d[i] = 1'b1;
                     rc_d[i]     = '0;
                  end else begin
                     rc_d[i] = rc_q[i] + 8'd1;
                  end
               end
               default: begin
                  state_d[i] = ST_IDLE;
                  rc_d[i]    = '0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk_cam or negedge reset_n) begin
      if (!reset_n) begin
         meta_q    <= '0;
         sync_q    <= '0;
         level_q   <= '0;
         press_q   <= '0;
         release_q <= '0;
         repeat_q  <= '0;
         for (int i = 0; i < NUM_BTNS; i++) begin
            cnt_q[i]   <= '0;
            rc_q[i]    <= '0;
            state_q[i] <= ST_IDLE;
         end
      end else begin
         meta_q    <= btn_raw;
         sync_q    <= meta_q;
         level_q   <= level_d;
         press_q   <= rise;
         release_q <= fall;
         repeat_q  <= repeat_d;
         cnt_q     <= cnt_d;
         rc_q      <= rc_d;
         state_q   <= state_d;
      end
   end

   assign btn_level   = level_q;
   assign btn_press   = press_q;
   assign btn_release = release_q;
   assign btn_repeat  = repeat_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer: one table row per 10-cycle tick period,
// plus hand-written bounce and reset-mid-repeat sequences.
module tb_button_debouncer;

   localparam int NB = 5;
   localparam int NV = 45;

   typedef struct {
      logic [NB-1:0] raw;
      logic [NB-1:0] lvl;
      logic [NB-1:0] pr;
      logic [NB-1:0] rl;
      logic [NB-1:0] rp;
   } vec_t;

   logic          clk_cam;
   logic          reset_n;
   logic          clk_debounce;
   logic [NB-1:0] btn_raw;
   logic [NB-1:0] btn_level;
   logic [NB-1:0] btn_press;
   logic [NB-1:0] btn_release;
   logic [NB-1:0] btn_repeat;

   int   n_vec;
   int   n_miss;
   vec_t vecs [NV];

   button_debouncer #(
      .NUM_BTNS    (NB),
      .STABLE_TICKS(2),
      .REPEAT_DELAY(3),
      .REPEAT_RATE (2)
   ) dut (
      .clk_cam     (clk_cam),
      .reset_n     (reset_n),
      .clk_debounce(clk_debounce),
      .btn_raw     (btn_raw),
      .btn_level   (btn_level),
      .btn_press   (btn_press),
      .btn_release (btn_release),
      .btn_repeat  (btn_repeat)
   );

   initial clk_cam = 1'b0;
   always #5 clk_cam = ~clk_cam;

   task automatic check(input string name, input logic [4*NB-1:0] act, input logic [4*NB-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got lvl/pr/rl/rp=%b_%b_%b_%b expected %b_%b_%b_%b at %0t", name,
                  act[4*NB-1:3*NB], act[3*NB-1:2*NB], act[2*NB-1:NB], act[NB-1:0],
                  exp[4*NB-1:3*NB], exp[3*NB-1:2*NB], exp[2*NB-1:NB], exp[NB-1:0], $time);
      end
   endtask

   function automatic logic [4*NB-1:0] outs();
      return {btn_level, btn_press, btn_release, btn_repeat};
   endfunction

   // One tick period: nine idle cycles then a tick; strobes must be clear
   // after the first idle edge, full output set compared after the tick edge.
   task automatic run_rows(input int first, input int last);
      for (int r = first; r <= last; r++) begin
         for (int k = 0; k < 10; k++) begin
            @(negedge clk_cam);
            btn_raw      = vecs[r].raw;
            clk_debounce = (k == 9);
            @(posedge clk_cam);
            #1;
            if (k == 0)
               check($sformatf("row%0d_strobe_clear", r), {btn_press, btn_release, btn_repeat}, '0);
            if (k == 9)
               check($sformatf("row%0d", r), outs(),
                     {vecs[r].lvl, vecs[r].pr, vecs[r].rl, vecs[r].rp});
         end
      end
   endtask

   initial begin
      n_vec  = 0;
      n_miss = 0;
      //            raw       level     press     release   repeat
      vecs[0]  = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
      vecs[1]  = '{5'b00001, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
      vecs[2]  = '{5'b00001, 5'b00001, 5'b00001, 5'b00000, 5'b00000};
      vecs[3]  = '{5'b00001, 5'b00001, 5'b00000, 5'b00000, 5'b00000};
      vecs[4]  = '{5'b00000, 5'b00001, 5'b00000, 5'b00000, 5'b00000};
      vecs[5]  = '{5'b00000, 5'b00000, 5'b00000, 5'b00001, 5'b00000};
      vecs[6]  = '{5'b10001, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
      vecs[7]  = '{5'b10001, 5'b10001, 5'b10001, 5'b00000, 5'b00000};
      vecs[8]  = '{5'b10001, 5'b10001, 5'b00000, 5'b00000, 5'b00000};
      vecs[9]  = '{5'b10001, 5'b10001, 5'b00000, 5'b00000, 5'b00000};
      vecs[10] = '{5'b10001, 5'b10001, 5'b00000, 5'b00000, 5'b10001};
      vecs[11] = '{5'b10001, 5'b10001, 5'b00000, 5'b00000, 5'b00000};
      vecs[12] = '{5'b10001, 5'b10001, 5'b00000, 5'b00000, 5'b10001};
      vecs[13] = '{5'b00000, 5'b10001, 5'b00000, 5'b00000, 5'b00000};
      vecs[14] = '{5'b00000, 5'b00000, 5'b00000, 5'b10001, 5'b00000};
      vecs[15] = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
      // bit 2 settles high after the bounce burst
      vecs[16] = '{5'b00100, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
      vecs[17] = '{5'b00100, 5'b00100, 5'b00100, 5'b00000, 5'b00000};
      vecs[18] = '{5'b00000, 5'b00100, 5'b00000, 5'b00000, 5'b00000};
      vecs[19] = '{5'b00000, 5'b00000, 5'b00000, 5'b00100, 5'b00000};
      // bit 3 auto-repeat: press flip at row 21, repeats 3,5,7,9,11 ticks later
      vecs[20] = '{5'b01000, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
      vecs[21] = '{5'b01000, 5'b01000, 5'b01000, 5'b00000, 5'b00000};
      vecs[22] = '{5'b01000, 5'b01000, 5'b00000, 5'b00000, 5'b00000};
      vecs[23] = '{5'b01000, 5'b01000, 5'b00000, 5'b00000, 5'b00000};
      vecs[24] = '{5'b01000, 5'b01000, 5'b00000, 5'b00000, 5'b01000};
      vecs[25] = '{5'b01000, 5'b01000, 5'b00000, 5'b00000, 5'b00000};
      vecs[26] = '{5'b01000, 5'b01000, 5'b00000, 5'b00000, 5'b01000};
      vecs[27] = '{5'b01000, 5'b01000, 5'b00000, 5'b00000, 5'b00000};
      vecs[28] = '{5'b01000, 5'b01000, 5'b00000, 5'b00000, 5'b01000};
      vecs[29] = '{5'b01000, 5'b01000, 5'b00000, 5'b00000, 5'b00000};
      vecs[30] = '{5'b01000, 5'b01000, 5'b00000, 5'b00000, 5'b01000};
      vecs[31] = '{5'b01000, 5'b01000, 5'b00000, 5'b00000, 5'b00000};
      vecs[32] = '{5'b01000, 5'b01000, 5'b00000, 5'b00000, 5'b01000};
      vecs[33] = '{5'b00000, 5'b01000, 5'b00000, 5'b00000, 5'b00000};
      vecs[34] = '{5'b00000, 5'b00000, 5'b00000, 5'b01000, 5'b00000};
      vecs[35] = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
      // bit 3 back into REPEATING ahead of the reset pulse
      vecs[36] = '{5'b01000, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
      vecs[37] = '{5'b01000, 5'b01000, 5'b01000, 5'b00000, 5'b00000};
      vecs[38] = '{5'b01000, 5'b01000, 5'b00000, 5'b00000, 5'b00000};
      vecs[39] = '{5'b01000, 5'b01000, 5'b00000, 5'b00000, 5'b00000};
      vecs[40] = '{5'b01000, 5'b01000, 5'b00000, 5'b00000, 5'b01000};
      // after reset, still held: fresh press with normal latency
      vecs[41] = '{5'b01000, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
      vecs[42] = '{5'b01000, 5'b01000, 5'b01000, 5'b00000, 5'b00000};
      vecs[43] = '{5'b00000, 5'b01000, 5'b00000, 5'b00000, 5'b00000};
      vecs[44] = '{5'b00000, 5'b00000, 5'b00000, 5'b01000, 5'b00000};

      reset_n      = 1'b0;
      clk_debounce = 1'b0;
      btn_raw      = '0;
      #1;
      check("reset_outputs", outs(), '0);
      repeat (3) @(posedge clk_cam);
      @(negedge clk_cam);
      reset_n = 1'b1;

      run_rows(0, 15);

      // Bit 2 toggles every 3 cycles; ticks sample it as 0,0,1,0 so the
      // agree counter never reaches 2 during the burst.
      for (int c = 0; c < 40; c++) begin
         @(negedge clk_cam);
         btn_raw      = '0;
         btn_raw[2]   = ((c / 3) % 2 == 1);
         clk_debounce = (c % 10 == 4);
         @(posedge clk_cam);
         #1;
         check($sformatf("bounce_c%0d", c), outs(), '0);
      end

      run_rows(16, 40);

      @(negedge clk_cam);
      clk_debounce = 1'b0;
      reset_n      = 1'b0;
      #1;
      check("async_reset_drop", outs(), '0);
      @(posedge clk_cam);
      #1;
      check("reset_held_no_release", outs(), '0);
      @(negedge clk_cam);
      reset_n = 1'b1;

      run_rows(41, 44);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
